// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the conv engine job scheduler.
package conv_sched_pkg;

  // Scheduler FSM states: wait for a request, hand the job to the engine,
  // watch the engine work, then report completion.
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_LAUNCH = 2'd1,
    STATE_RUN    = 2'd2,
    STATE_DONE   = 2'd3
  } state_t;

  // Requester index that follows id in round-robin order.
  function automatic int rr_next_index(input int id, input int num_req);
    return (id + 1) % num_req;
  endfunction

endpackage

// File: rtl/conv_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above
// rr_ptr, wrapping around to index 0.
module conv_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  pick,
  output logic [ID_WIDTH-1:0] id,
  output logic                any
);

  logic [ID_WIDTH-1:0] scan_idx;

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin
    pick     = '0;
    id       = '0;
    any      = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any && req[scan_idx]) begin
        any            = 1'b1;
        id             = scan_idx;
        pick[scan_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Round-robin scheduler sharing one conv engine among NUM_REQ requesters.
// Grants one job at a time, steers the bank mux, launches the engine and
// detects job end from the engine's last result-column write.
module conv_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int BANK_ADDR_WIDTH     = 2,
  parameter int IMG_H               = 8,
  parameter int FILTER_H            = 3,
  parameter int RESULT_H            = IMG_H - FILTER_H + 1,
  parameter int RESULT_H_ADDR_WIDTH = $clog2(RESULT_H),
  parameter int TIMEOUT_CYCLES      = 64,
  parameter int JOB_CNT_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0] req_bank,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [NUM_REQ-1:0]                 done,
  output logic [BANK_ADDR_WIDTH-1:0]         bank_sel,
  output logic                               eng_val_in,
  input  logic                               eng_rdy_in,
  input  logic                               eng_last_wren,
  input  logic [RESULT_H_ADDR_WIDTH-1:0]     eng_last_wraddr,
  output logic                               busy,
  output logic                               err,
  output logic [JOB_CNT_WIDTH-1:0]           job_count
);

  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                     state_reg, state_next;
  logic [NUM_REQ-1:0]         grant_reg, grant_next;
  logic [NUM_REQ-1:0]         done_reg, done_next;
  logic [BANK_ADDR_WIDTH-1:0] bank_sel_reg, bank_sel_next;
  logic                       eng_val_reg, eng_val_next;
  logic [ID_WIDTH-1:0]        owner_reg, owner_next;
  logic [ID_WIDTH-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [CNT_WIDTH-1:0]       run_cnt_reg, run_cnt_next;
  logic                       err_reg, err_next;
  logic [JOB_CNT_WIDTH-1:0]   job_count_reg, job_count_next;

  logic [NUM_REQ-1:0]         arb_pick;
  logic [ID_WIDTH-1:0]        arb_id;
  logic                       arb_any;
  logic                       job_complete;
  logic                       run_expired;
  logic [BANK_ADDR_WIDTH-1:0] bank_of [NUM_REQ];

  // Unpack the flat per-requester bank selects.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bank
      assign bank_of[gi] = req_bank[gi*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
    end
  endgenerate

  conv_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .pick   (arb_pick),
    .id     (arb_id),
    .any    (arb_any)
  );

  // Only the write to the final result row marks the end of a job.
  assign job_complete = eng_last_wren &&
                        (eng_last_wraddr == RESULT_H_ADDR_WIDTH'(RESULT_H - 1));
  assign run_expired  = (run_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Next-state logic for the FSM, counters and registered outputs.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    done_next      = '0;
    bank_sel_next  = bank_sel_reg;
    eng_val_next   = eng_val_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    run_cnt_next   = run_cnt_reg;
    err_next       = err_reg;
    job_count_next = job_count_reg;
    case (state_reg)
      STATE_IDLE: begin
        if (arb_any) begin
          owner_next    = arb_id;
          grant_next    = arb_pick;
          bank_sel_next = bank_of[arb_id];
          eng_val_next  = 1'b1;
          state_next    = STATE_LAUNCH;
        end
      end
      STATE_LAUNCH: begin
        // No timeout here: a busy engine may hold us off indefinitely.
        if (eng_val_reg && eng_rdy_in) begin
          eng_val_next = 1'b0;
          run_cnt_next = '0;
          state_next   = STATE_RUN;
        end
      end
      STATE_RUN: begin
        run_cnt_next = run_cnt_reg + CNT_WIDTH'(1);
        // Completion takes priority over a simultaneous timeout.
        if (job_complete || run_expired) begin
          if (!job_complete) begin
            err_next = 1'b1;
          end
          done_next      = grant_reg;
          job_count_next = job_count_reg + JOB_CNT_WIDTH'(1);
          rr_ptr_next    = ID_WIDTH'(rr_next_index(int'(owner_reg), NUM_REQ));
          state_next     = STATE_DONE;
        end
      end
      STATE_DONE: begin
        grant_next = '0;
        state_next = STATE_IDLE;
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  // State register; reset aborts any job in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= STATE_IDLE;
      grant_reg     <= '0;
      done_reg      <= '0;
      bank_sel_reg  <= '0;
      eng_val_reg   <= 1'b0;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      run_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      job_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      bank_sel_reg  <= bank_sel_next;
      eng_val_reg   <= eng_val_next;
      owner_reg     <= owner_next;
      rr_ptr_reg    <= rr_ptr_next;
      run_cnt_reg   <= run_cnt_next;
      err_reg       <= err_next;
      job_count_reg <= job_count_next;
    end
  end

  assign grant      = grant_reg;
  assign done       = done_reg;
  assign bank_sel   = bank_sel_reg;
  assign eng_val_in = eng_val_reg;
  assign busy       = (state_reg != STATE_IDLE);
  assign err        = err_reg;
  assign job_count  = job_count_reg;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Scoreboard bench for conv_job_scheduler: jobs are issued against a
// round-robin reference model; a negedge monitor checks grants and dones.
module tb_conv_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int BW      = 2;
  localparam int RA      = 3;
  localparam int TMO     = 16;
  localparam int JW      = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*BW-1:0] req_bank;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic [BW-1:0]        bank_sel;
  logic                 eng_val_in;
  logic                 eng_rdy_in;
  logic                 eng_last_wren;
  logic [RA-1:0]        eng_last_wraddr;
  logic                 busy;
  logic                 err;
  logic [JW-1:0]        job_count;

  always #5 clk = ~clk;

  conv_job_scheduler #(
    .NUM_REQ         (NUM_REQ),
    .BANK_ADDR_WIDTH (BW),
    .IMG_H           (8),
    .FILTER_H        (3),
    .TIMEOUT_CYCLES  (TMO),
    .JOB_CNT_WIDTH   (JW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_bank        (req_bank),
    .grant           (grant),
    .done            (done),
    .bank_sel        (bank_sel),
    .eng_val_in      (eng_val_in),
    .eng_rdy_in      (eng_rdy_in),
    .eng_last_wren   (eng_last_wren),
    .eng_last_wraddr (eng_last_wraddr),
    .busy            (busy),
    .err             (err),
    .job_count       (job_count)
  );

  typedef struct packed { logic [3:0] grant; logic [1:0] bank; } gexp_t;
  typedef struct packed { logic [3:0] done; logic [15:0] jobs; logic err; } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: rotating pointer, completed-job count, sticky error.
  int m_ptr  = 0;
  int m_jobs = 0;
  bit m_err  = 1'b0;

  logic [3:0] prev_grant = '0;
  logic [3:0] prev_done  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec rule: first set bit searching upward from the pointer, wrapping.
  function automatic int model_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [RA-1:0] bad_addr();
    int v;
    v = $urandom_range(0, 6);
    if (v >= 5) v++;
    return RA'(v);
  endfunction

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (prev_done != 0) begin
      check("grant_cleared_after_done", 32'(grant), 32'h0);
      check("done_single_cycle", 32'(done), 32'h0);
    end else if (done != 0) begin
      if (dq.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        dexp_t e;
        e = dq.pop_front();
        check("done_value", 32'(done), 32'(e.done));
        check("done_job_count", 32'(job_count), 32'(e.jobs));
        check("done_err", 32'(err), 32'(e.err));
        check("done_matches_grant", 32'(grant), 32'(e.done));
      end
    end
    if (grant != 0 && prev_grant == 0) begin
      if (gq.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'h0);
      end else begin
        gexp_t g;
        g = gq.pop_front();
        check("grant_value", 32'(grant), 32'(g.grant));
        check("grant_bank_sel", 32'(bank_sel), 32'(g.bank));
        check("grant_eng_val", 32'(eng_val_in), 32'h1);
        check("grant_busy", 32'(busy), 32'h1);
      end
    end
    prev_grant <= grant;
    prev_done  <= done;
  end

  // mode 0: complete after noise cycles; 1: let it time out; 2: reset mid-RUN.
  task automatic run_job(input logic [3:0] r, input logic [7:0] banks, input int stall,
                         input int mode, input int noise, input bit drop);
    int id;
    int lat;
    int cnt;
    logic [3:0] g;
    logic [1:0] b;
    @(negedge clk);
    req           = r;
    req_bank      = banks;
    eng_rdy_in    = (stall == 0);
    eng_last_wren = 1'b0;
    id = model_pick(r, m_ptr);
    g  = 4'(1 << id);
    b  = banks[id*2 +: 2];
    gq.push_back('{grant: g, bank: b});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (grant == 0 && lat < 20);
    check("grant_latency", 32'(lat), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check("launch_eng_val", 32'(eng_val_in), 32'h1);
      check("launch_grant_stable", 32'(grant), 32'(g));
      check("launch_bank_stable", 32'(bank_sel), 32'(b));
      req_bank        = ~banks;
      eng_last_wren   = (s == 0);
      eng_last_wraddr = RA'(5);
      @(negedge clk);
    end
    eng_last_wren = 1'b0;
    eng_rdy_in    = 1'b1;
    @(negedge clk);
    check("run_eng_val_low", 32'(eng_val_in), 32'h0);
    check("run_busy", 32'(busy), 32'h1);
    check("run_bank_held", 32'(bank_sel), 32'(b));
    eng_rdy_in = 1'($urandom_range(0, 1));
    if (drop) req = '0;
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_bank_sel", 32'(bank_sel), 32'h0);
      check("rst_eng_val", 32'(eng_val_in), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_job_count", 32'(job_count), 32'h0);
      req        = '0;
      eng_rdy_in = 1'b1;
      reset      = 1'b0;
      m_ptr  = 0;
      m_jobs = 0;
      m_err  = 1'b0;
      $display("job req=%b owner=%0d bank=%0d stall=%0d aborted by reset", r, id, b, stall);
      return;
    end
    if (mode == 1) begin
      m_jobs++;
      m_err = 1'b1;
      m_ptr = (id + 1) % NUM_REQ;
      dq.push_back('{done: g, jobs: 16'(m_jobs), err: m_err});
      cnt = 0;
      while (done == 0 && cnt < 40) begin
        eng_last_wren   = 1'($urandom_range(0, 1));
        eng_last_wraddr = bad_addr();
        @(negedge clk);
        cnt++;
      end
      eng_last_wren = 1'b0;
      check("timeout_run_cycles", 32'(cnt), 32'(TMO));
    end else begin
      for (int n = 0; n < noise; n++) begin
        eng_last_wren   = 1'($urandom_range(0, 1));
        eng_last_wraddr = bad_addr();
        @(negedge clk);
      end
      m_jobs++;
      m_ptr = (id + 1) % NUM_REQ;
      dq.push_back('{done: g, jobs: 16'(m_jobs), err: m_err});
      eng_last_wren   = 1'b1;
      eng_last_wraddr = RA'(5);
      @(negedge clk);
      eng_last_wren = 1'b0;
      check("done_after_last_write", 32'(done), 32'(g));
    end
    $display("job req=%b owner=%0d bank=%0d stall=%0d mode=%0d noise=%0d jobs=%0d err=%0d",
             r, id, b, stall, mode, noise, m_jobs, m_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    req             = '0;
    req_bank        = '0;
    eng_rdy_in      = 1'b1;
    eng_last_wren   = 1'b0;
    eng_last_wraddr = '0;
    repeat (2) @(negedge clk);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_bank_sel", 32'(bank_sel), 32'h0);
    check("reset_eng_val", 32'(eng_val_in), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_job_count", 32'(job_count), 32'h0);
    reset = 1'b0;

    // Single job, bank 2 for requester 0.
    run_job(4'b0001, 8'b0000_0010, 0, 0, 2, 1'b0);
    // Fairness with everyone requesting, then two requesters.
    repeat (5) run_job(4'b1111, 8'($urandom), 0, 0, 1, 1'b0);
    repeat (3) run_job(4'b1010, 8'($urandom), 0, 0, 1, 1'b0);
    // Stray wren in LAUNCH plus wrong-address writes in RUN.
    run_job(4'b0100, 8'($urandom), 2, 0, 6, 1'b1);
    // Completion on the last allowed RUN cycle beats the timeout.
    run_job(4'b0011, 8'($urandom), 0, 0, TMO - 1, 1'b0);
    // Timeout, then good jobs must keep err set.
    run_job(4'b1000, 8'($urandom), 0, 1, 0, 1'b0);
    run_job(4'b0110, 8'($urandom), 0, 0, 3, 1'b0);
    // Five-cycle engine stall in LAUNCH.
    run_job(4'b0101, 8'($urandom), 5, 0, 2, 1'b0);
    // Leave the pointer at 2, then reset mid-RUN.
    run_job(4'b0010, 8'($urandom), 0, 0, 1, 1'b0);
    run_job(4'b0100, 8'($urandom), 0, 2, 0, 1'b0);
    run_job(4'b0101, 8'($urandom), 0, 0, 1, 1'b0);
    run_job(4'b0100, 8'($urandom), 0, 0, 1, 1'b0);
    // Randomized traffic.
    repeat (30) begin
      run_job(4'($urandom_range(1, 15)), 8'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 10),
              1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    check("grant_queue_drained", 32'(gq.size()), 32'h0);
    check("done_queue_drained", 32'(dq.size()), 32'h0);
    check("final_job_count", 32'(job_count), 32'(m_jobs));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
